// File: rtl/alarm_controller_if.sv
// Signal bundle between the alarm-compare/front-panel side (master) and alarm_controller (slave).
interface alarm_controller_if #(
    parameter int SNOOZE_SEC = 300
);
    localparam int SLW = $clog2(SNOOZE_SEC + 1);

    // No valid/ready pairs here: activate_alarm/alarm_en are levels, sec_tick and the buttons
    // are one-cycle pulses consumed on the cycle they are high; outputs are registered levels.
    logic           activate_alarm;
    logic           alarm_en;
    logic           sec_tick;
    logic           snooze_btn;
    logic           stop_btn;
    logic           buzzer;
    logic           ringing;
    logic           snoozing;
    logic [SLW-1:0] snooze_left;
    logic [1:0]     state_dbg;

    modport master (
        output activate_alarm, alarm_en, sec_tick, snooze_btn, stop_btn,
        input  buzzer, ringing, snoozing, snooze_left, state_dbg
    );

    modport slave (
        input  activate_alarm, alarm_en, sec_tick, snooze_btn, stop_btn,
        output buzzer, ringing, snoozing, snooze_left, state_dbg
    );
endinterface

// File: rtl/alarm_controller.sv
// Alarm event manager: ring / snooze / stop / auto-timeout with a square-wave buzzer.
// Optional SNOOZE_LIMIT_EN caps the number of snoozes per alarm at MAX_SNOOZE.
module alarm_controller #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int BEEP_CYCLES      = 25_000_000,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic               clk,
    input  logic               reset,
    alarm_controller_if.slave  bus
);
    localparam int SLW = $clog2(SNOOZE_SEC + 1);
    localparam int RTW = $clog2(RING_TIMEOUT_SEC + 1);
    localparam int BCW = $clog2(BEEP_CYCLES + 1);

    localparam logic [SLW-1:0] SNOOZE_LOAD = SLW'(SNOOZE_SEC);
    localparam logic [RTW-1:0] RING_LAST   = RTW'(RING_TIMEOUT_SEC - 1);
    localparam logic [BCW-1:0] BEEP_LAST   = BCW'(BEEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           act_q, act_d;
    logic [RTW-1:0] ring_timer_q, ring_timer_d;
    logic [BCW-1:0] beep_cnt_q, beep_cnt_d;
    logic [SLW-1:0] snooze_left_q, snooze_left_d;
    logic           buzzer_q, buzzer_d;
    logic           ringing_q, ringing_d;
    logic           snoozing_q, snoozing_d;
    logic           trig;
    logic           snooze_ok;
    logic           enter_idle;

`ifdef SNOOZE_LIMIT_EN
    localparam int SCW = $clog2(MAX_SNOOZE + 1);
    localparam logic [SCW-1:0] SNZ_MAX = SCW'(MAX_SNOOZE);

    logic [SCW-1:0] snz_cnt_q, snz_cnt_d;

    assign snooze_ok = bus.snooze_btn && (snz_cnt_q != SNZ_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snz_cnt_q <= '0;
        end else begin
            snz_cnt_q <= snz_cnt_d;
        end
    end

    always_comb begin
        snz_cnt_d = snz_cnt_q;
        if (enter_idle || state_q == S_IDLE) begin
            snz_cnt_d = '0;
        end else if (state_q == S_RINGING && state_d == S_SNOOZE) begin
            snz_cnt_d = snz_cnt_q + SCW'(1);
        end
    end
`else
    assign snooze_ok = bus.snooze_btn;
`endif

    // act_q resets high so a match already present when reset releases is not an edge.
    assign trig  = bus.activate_alarm & ~act_q;
    assign act_d = bus.activate_alarm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            act_q         <= 1'b1;
            ring_timer_q  <= '0;
            beep_cnt_q    <= '0;
            snooze_left_q <= '0;
            buzzer_q      <= 1'b0;
            ringing_q     <= 1'b0;
            snoozing_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            act_q         <= act_d;
            ring_timer_q  <= ring_timer_d;
            beep_cnt_q    <= beep_cnt_d;
            snooze_left_q <= snooze_left_d;
            buzzer_q      <= buzzer_d;
            ringing_q     <= ringing_d;
            snoozing_q    <= snoozing_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ring_timer_d  = ring_timer_q;
        beep_cnt_d    = beep_cnt_q;
        snooze_left_d = snooze_left_q;
        buzzer_d      = buzzer_q;
        enter_idle    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ring_timer_d  = '0;
                beep_cnt_d    = '0;
                snooze_left_d = '0;
                buzzer_d      = 1'b0;
                if (trig && bus.alarm_en) begin
                    state_d  = S_RINGING;
                    buzzer_d = 1'b1;
                end
            end

            S_RINGING: begin
                if (!bus.alarm_en || bus.stop_btn) begin
                    enter_idle = 1'b1;
                end else if (snooze_ok) begin
                    // A tick coinciding with the snooze press is deliberately dropped.
                    state_d       = S_SNOOZE;
                    snooze_left_d = SNOOZE_LOAD;
                    beep_cnt_d    = '0;
                    buzzer_d      = 1'b0;
                end else begin
                    if (beep_cnt_q == BEEP_LAST) begin
                        beep_cnt_d = '0;
                        buzzer_d   = ~buzzer_q;
                    end else begin
                        beep_cnt_d = beep_cnt_q + BCW'(1);
                    end
                    if (bus.sec_tick) begin
                        if (ring_timer_q == RING_LAST) begin
                            enter_idle = 1'b1;
                        end else begin
                            ring_timer_d = ring_timer_q + RTW'(1);
                        end
                    end
                end
            end

            S_SNOOZE: begin
                if (!bus.alarm_en || bus.stop_btn) begin
                    enter_idle = 1'b1;
                end else if (bus.sec_tick) begin
                    if (snooze_left_q == SLW'(1)) begin
                        state_d       = S_RINGING;
                        snooze_left_d = '0;
                        ring_timer_d  = '0;
                        beep_cnt_d    = '0;
                        buzzer_d      = 1'b1;
                    end else begin
                        snooze_left_d = snooze_left_q - SLW'(1);
                    end
                end
            end

            default: begin
                enter_idle = 1'b1;
            end
        endcase

        if (enter_idle) begin
            state_d       = S_IDLE;
            ring_timer_d  = '0;
            beep_cnt_d    = '0;
            snooze_left_d = '0;
            buzzer_d      = 1'b0;
        end
    end

    assign ringing_d  = (state_d == S_RINGING);
    assign snoozing_d = (state_d == S_SNOOZE);

    assign bus.buzzer      = buzzer_q;
    assign bus.ringing     = ringing_q;
    assign bus.snoozing    = snoozing_q;
    assign bus.snooze_left = snooze_left_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_alarm_controller.sv
// Directed scenarios followed by random stimulus, all checked cycle by cycle against a
// seconds/cycles-elapsed reference model of the alarm behaviour.
module tb_alarm_controller;
    localparam int SNOOZE_SEC       = 3;
    localparam int RING_TIMEOUT_SEC = 5;
    localparam int BEEP_CYCLES      = 4;
    localparam int MAX_SNOOZE       = 2;

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    alarm_controller_if #(.SNOOZE_SEC(SNOOZE_SEC)) bus ();

    alarm_controller #(
        .SNOOZE_SEC      (SNOOZE_SEC),
        .RING_TIMEOUT_SEC(RING_TIMEOUT_SEC),
        .BEEP_CYCLES     (BEEP_CYCLES),
        .MAX_SNOOZE      (MAX_SNOOZE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: what the alarm is doing, how long it has done it.
    int m_mode;
    int m_act_prev;
    int m_ring_secs;
    int m_ring_cyc;
    int m_left;
    int m_snoozes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode      = M_IDLE;
        m_act_prev  = 1;
        m_ring_secs = 0;
        m_ring_cyc  = 0;
        m_left      = 0;
        m_snoozes   = 0;
    endtask

    task automatic model_go_idle();
        m_mode    = M_IDLE;
        m_left    = 0;
        m_snoozes = 0;
    endtask

    task automatic model_start_ring();
        m_mode      = M_RING;
        m_ring_secs = 0;
        m_ring_cyc  = 0;
    endtask

    function automatic bit snooze_allowed();
`ifdef SNOOZE_LIMIT_EN
        return m_snoozes < MAX_SNOOZE;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step();
        bit trig;
        if (reset) begin
            model_reset();
            return;
        end
        trig = bus.activate_alarm && (m_act_prev == 0);
        m_act_prev = bus.activate_alarm ? 1 : 0;
        case (m_mode)
            M_IDLE: begin
                if (trig && bus.alarm_en) model_start_ring();
            end
            M_RING: begin
                if (!bus.alarm_en || bus.stop_btn) begin
                    model_go_idle();
                end else if (bus.snooze_btn && snooze_allowed()) begin
                    m_mode = M_SNZ;
                    m_left = SNOOZE_SEC;
                    m_snoozes++;
                end else begin
                    m_ring_cyc++;
                    if (bus.sec_tick) begin
                        m_ring_secs++;
                        if (m_ring_secs == RING_TIMEOUT_SEC) model_go_idle();
                    end
                end
            end
            default: begin
                if (!bus.alarm_en || bus.stop_btn) begin
                    model_go_idle();
                end else if (bus.sec_tick) begin
                    m_left--;
                    if (m_left == 0) model_start_ring();
                end
            end
        endcase
    endtask

    task automatic check_all(input string where);
        logic exp_ring, exp_snz, exp_buz;
        int   exp_left;
        exp_ring = (m_mode == M_RING);
        exp_snz  = (m_mode == M_SNZ);
        exp_buz  = (m_mode == M_RING) && (((m_ring_cyc / BEEP_CYCLES) % 2) == 0);
        exp_left = (m_mode == M_SNZ) ? m_left : 0;
        chk({where, ".ringing"}, 32'(bus.ringing), 32'(exp_ring));
        chk({where, ".snoozing"}, 32'(bus.snoozing), 32'(exp_snz));
        chk({where, ".buzzer"}, 32'(bus.buzzer), 32'(exp_buz));
        chk({where, ".snooze_left"}, 32'(bus.snooze_left), 32'(exp_left));
    endtask

    task automatic cycle(input string where);
        @(posedge clk);
        model_step();
        #1;
        check_all(where);
    endtask

    task automatic run(input int n, input string where);
        for (int i = 0; i < n; i++) cycle(where);
    endtask

    task automatic pulse_tick(input string where);
        bus.sec_tick = 1'b1;
        cycle(where);
        bus.sec_tick = 1'b0;
    endtask

    task automatic pulse_snooze(input string where);
        bus.snooze_btn = 1'b1;
        cycle(where);
        bus.snooze_btn = 1'b0;
    endtask

    task automatic pulse_stop(input string where);
        bus.stop_btn = 1'b1;
        cycle(where);
        bus.stop_btn = 1'b0;
    endtask

    task automatic start_ring(input string where);
        bus.activate_alarm = 1'b0;
        cycle(where);
        bus.activate_alarm = 1'b1;
        cycle(where);
        bus.activate_alarm = 1'b0;
    endtask

    initial begin
        bus.activate_alarm = 1'b0;
        bus.alarm_en       = 1'b0;
        bus.sec_tick       = 1'b0;
        bus.snooze_btn     = 1'b0;
        bus.stop_btn       = 1'b0;
        model_reset();

        // Reset state
        run(3, "reset");
        #2 reset = 1'b0;
        run(2, "post_reset");

        // Basic ring / stop, beep waveform, no retrigger while held
        bus.alarm_en = 1'b1;
        bus.activate_alarm = 1'b1;
        cycle("basic");
        chk("basic_ring_now", 32'(bus.ringing), 32'd1);
        chk("basic_buzz_now", 32'(bus.buzzer), 32'd1);
        run(10, "basic_beep");
        pulse_stop("basic_stop");
        chk("basic_stopped", 32'(bus.ringing), 32'd0);
        run(4, "basic_held");
        bus.activate_alarm = 1'b0;
        cycle("basic_low");

        // Snooze countdown back into ringing
        start_ring("snz");
        pulse_snooze("snz_press");
        chk("snz_left_load", 32'(bus.snooze_left), 32'd3);
        for (int i = 0; i < 3; i++) begin
            run(2, "snz_wait");
            pulse_tick("snz_tick");
        end
        chk("snz_reringing", 32'(bus.ringing), 32'd1);
        chk("snz_left_zero", 32'(bus.snooze_left), 32'd0);
        pulse_stop("snz_stop");

        // Timeout after the fifth tick
        start_ring("tmo");
        for (int i = 0; i < 4; i++) begin
            run(2, "tmo_wait");
            pulse_tick("tmo_tick");
        end
        chk("tmo_still_ring", 32'(bus.ringing), 32'd1);
        pulse_tick("tmo_fifth");
        chk("tmo_silenced", 32'(bus.ringing), 32'd0);

        // Snooze and tick together: tick dropped
        start_ring("snz_tick");
        bus.snooze_btn = 1'b1;
        bus.sec_tick   = 1'b1;
        cycle("snz_tick_same");
        bus.snooze_btn = 1'b0;
        bus.sec_tick   = 1'b0;
        chk("snz_tick_left", 32'(bus.snooze_left), 32'd3);
        pulse_tick("snz_tick_next");
        chk("snz_tick_left2", 32'(bus.snooze_left), 32'd2);
        pulse_snooze("snz_ignored");
        pulse_stop("snz_tick_stop");

        // Priority and disable
        start_ring("prio");
        bus.stop_btn   = 1'b1;
        bus.snooze_btn = 1'b1;
        cycle("prio_both");
        bus.stop_btn   = 1'b0;
        bus.snooze_btn = 1'b0;
        chk("prio_idle", 32'(bus.snoozing), 32'd0);
        start_ring("dis");
        pulse_snooze("dis_snooze");
        bus.alarm_en = 1'b0;
        cycle("dis_drop");
        chk("dis_idle", 32'(bus.snoozing), 32'd0);
        start_ring("dis_off");
        chk("dis_no_ring", 32'(bus.ringing), 32'd0);
        bus.alarm_en = 1'b1;
        cycle("dis_rearm");

        // Snooze limit
        start_ring("lim");
        for (int k = 0; k < 2; k++) begin
            pulse_snooze("lim_snz");
            for (int i = 0; i < 3; i++) pulse_tick("lim_tick");
        end
        pulse_snooze("lim_third");
`ifdef SNOOZE_LIMIT_EN
        chk("lim_still_ring", 32'(bus.ringing), 32'd1);
`else
        chk("lim_third_taken", 32'(bus.snoozing), 32'd1);
`endif
        pulse_stop("lim_stop");

        // Asynchronous reset mid-ring with the match held high
        bus.activate_alarm = 1'b1;
        cycle("arst_ring");
        run(2, "arst_ring");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("arst_now");
        chk("arst_ring_off", 32'(bus.ringing), 32'd0);
        run(3, "arst_hold");
        #2 reset = 1'b0;
        run(6, "arst_release");
        chk("arst_no_ring", 32'(bus.ringing), 32'd0);
        bus.activate_alarm = 1'b0;
        cycle("arst_low");
        bus.activate_alarm = 1'b1;
        cycle("arst_rise");
        chk("arst_rering", 32'(bus.ringing), 32'd1);
        pulse_stop("arst_stop");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) bus.activate_alarm = ~bus.activate_alarm;
            bus.alarm_en   = ($urandom_range(0, 59) != 0);
            bus.sec_tick   = ($urandom_range(0, 3) == 0);
            bus.snooze_btn = ($urandom_range(0, 11) == 0);
            bus.stop_btn   = ($urandom_range(0, 79) == 0);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alarm_controller.md
# alarm_controller

Consumer of the time/alarm-compare match signal: turns the level `activate_alarm` into a managed alarm event with ringing, snooze, stop and auto-timeout. Sits between the alarm-compare logic and the buzzer/LED outputs, with debounced front-panel buttons and the 1 Hz tick from the timekeeping chain as inputs. All state is sequential; outputs are registered.

## Interface
- `SNOOZE_SEC`, 300: snooze duration in seconds (≥1).
- `RING_TIMEOUT_SEC`, 60: seconds of continuous ringing before auto-silence (≥1).
- `BEEP_CYCLES`, 25_000_000: clk cycles per buzzer half-period (≥1).
- `MAX_SNOOZE`, 3: snooze limit, used only with `SNOOZE_LIMIT_EN`.
- `clk` in 1: system clock; everything is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `activate_alarm` in 1: level; high while current time equals alarm setting.
- `alarm_en` in 1: level; alarm armed.
- `sec_tick` in 1: single-cycle pulse once per second.
- `snooze_btn` in 1: single-cycle debounced pulse.
- `stop_btn` in 1: single-cycle debounced pulse.
- `buzzer` out 1: beep waveform.
- `ringing` out 1: high in RINGING.
- `snoozing` out 1: high in SNOOZE.
- `snooze_left` out `$clog2(SNOOZE_SEC+1)`: seconds remaining in SNOOZE; 0 otherwise.

## Operation
- FSM states are IDLE, RINGING and SNOOZE. Reset state is IDLE.
- Trigger is the rising edge of `activate_alarm`: `act_q` registered, `trig = activate_alarm & ~act_q`. `act_q` resets to 1, so a match already present at reset release does not ring.
- IDLE to RINGING: `trig & alarm_en`. The ring timer clears, the beep counter clears and `buzzer` goes to 1.
- Priority in RINGING is `!alarm_en` > `stop_btn` > `snooze_btn` > timeout:
  - `!alarm_en` or `stop_btn`: go to IDLE.
  - `snooze_btn`: go to SNOOZE, load `snooze_left=SNOOZE_SEC`, increment the snooze count. A `sec_tick` in the same cycle is ignored.
  - On `sec_tick`, the ring timer increments. A tick with ring timer at `RING_TIMEOUT_SEC-1` goes to IDLE.
- Priority in SNOOZE is `!alarm_en` > `stop_btn` > tick:
  - `!alarm_en` or `stop_btn`: go to IDLE.
  - `sec_tick`: decrement `snooze_left`. A tick at `snooze_left==1` goes to RINGING with the ring timer and beep counter reloaded.
  - `snooze_btn` has no effect.
- `trig` is ignored outside IDLE.
- Entering IDLE clears the snooze count, `snooze_left` and `buzzer`.
- Buzzer in RINGING: the beep counter counts 0..`BEEP_CYCLES-1`. At the terminal count, `buzzer` toggles and the counter wraps to 0. `buzzer` is 0 in IDLE and SNOOZE.
- Counter widths are `$clog2` of their maximum plus 1. No counter wraps except the beep counter.

## Timing
- Every output resets to 0.
- Latency is 1 cycle from the input sample edge to the state/output change.
- Example: `activate_alarm` rising at edge N is sampled at N, so `ringing`=1 and `buzzer`=1 after edge N.
- Buttons and `sec_tick` are sampled only on the cycle they are high.
- Reset mid-operation returns the block to IDLE immediately (async). No ring occurs on release while `activate_alarm` stays high.

## Configuration
- `SNOOZE_LIMIT_EN`, defined: snooze count saturates at `MAX_SNOOZE`. Once the count equals `MAX_SNOOZE`, `snooze_btn` in RINGING is ignored; only stop, disable or timeout end ringing.
- `SNOOZE_LIMIT_EN`, undefined: snooze is unlimited and the snooze-count register is not built.

## Test plan
Params for all scenarios: `SNOOZE_SEC`=3, `RING_TIMEOUT_SEC`=5, `BEEP_CYCLES`=4, `MAX_SNOOZE`=2.

- Basic ring/stop: `alarm_en`=1, `activate_alarm` 0→1 → `ringing`=1 the next cycle; `buzzer` toggles every 4 cycles; `stop_btn` → IDLE with all outputs 0; `activate_alarm` held high does not re-trigger.
- Snooze: ring, then `snooze_btn` → `snoozing`=1 and `snooze_left`=3, counting 3→2→1 on ticks; the 3rd tick → `ringing`=1 and `snooze_left`=0.
- Timeout: ring with no buttons → the 5th `sec_tick` returns to IDLE; snooze+tick in the same cycle → SNOOZE with `snooze_left`=3.
- Priority/disable: `stop_btn` and `snooze_btn` in the same cycle → IDLE; `alarm_en` dropped in SNOOZE → IDLE; `activate_alarm` rising with `alarm_en`=0 → stays IDLE.
- Reset: assert `reset` mid-RINGING with `activate_alarm` high → all outputs 0 asynchronously; on release, no ring until `activate_alarm` falls and rises again.
- `SNOOZE_LIMIT_EN`: two snoozes accepted; the third `snooze_btn` is ignored and `ringing` stays 1. Without the macro, the third snooze is accepted.
